// File: rtl/matrix_xfer_engine_pkg.sv
// Shared definitions for the matrix load/store transfer engine and its decoder.
package matrix_xfer_engine_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    // Opcodes shared with the decoder that produces this block's control word.
    localparam logic [5:0] OP_MLD  = 6'b000000;
    localparam logic [5:0] OP_MSTR = 6'b000001;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_SCAN = S_SCAN,
        ST_RD   = S_RD,
        ST_WB   = S_WB,
        ST_WR   = S_WR,
        ST_FIN  = S_FIN
    } state_e;

endpackage

// File: rtl/matrix_xfer_engine_lane_scan.sv
// Combinational priority finder: lowest enabled lane at or above the start pointer.
module matrix_xfer_engine_lane_scan
    import matrix_xfer_engine_pkg::*;
(
    input  logic [NUM_LANES-1:0] mask_i,
    input  logic [1:0]           ptr_i,
    output logic                 found_o,
    output logic [1:0]           lane_o
);

    // Walk from the top down so the lowest qualifying lane is the last assignment.
    always_comb begin
        found_o = 1'b0;
        lane_o  = 2'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask_i[i] && (2'(i) >= ptr_i)) begin
                found_o = 1'b1;
                lane_o  = 2'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_xfer_engine.sv
// Moves a 2x2 matrix (4 lanes) between data memory and the matrix register file,
// one word per memory handshake, driven by the decoded MLD/MSTR control word.
module matrix_xfer_engine
    import matrix_xfer_engine_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MREG_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic                 reg_write_i,
    input  logic [NUM_LANES-1:0] lane_en_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [MREG_W-1:0]    mreg_idx_i,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic [MREG_W-1:0]    rf_idx_o,
    output logic [1:0]           rf_lane_o,
    output logic                 rf_we_o,
    output logic [DATA_W-1:0]    rf_wdata_o,
    input  logic [DATA_W-1:0]    rf_rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           state_o
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e                 state_q;
    logic                   rd_q;
    logic                   reg_wr_q;
    logic [NUM_LANES-1:0]   lanes_q;
    logic [ADDR_W-1:0]      base_q;
    logic [MREG_W-1:0]      mreg_q;
    logic [2:0]             ptr_q;
    logic [1:0]             lane_q;
    logic [TMO_W-1:0]       tmo_q;

    logic [ADDR_W-1:0]      mem_addr_q;
    logic                   mem_re_q;
    logic                   mem_we_q;
    logic [MREG_W-1:0]      rf_idx_q;
    logic [1:0]             rf_lane_q;
    logic                   rf_we_q;
    logic [DATA_W-1:0]      rf_wdata_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic                   scan_found;
    logic [1:0]             scan_lane;
    logic                   scan_hit;
    logic [ADDR_W-1:0]      addr_d;
    logic [2:0]             ptr_d;

    matrix_xfer_engine_lane_scan u_lane_scan (
        .mask_i  (lanes_q),
        .ptr_i   (ptr_q[1:0]),
        .found_o (scan_found),
        .lane_o  (scan_lane)
    );

    // ptr_q[2] marks "past lane 3": nothing can remain once it is set.
    assign scan_hit = scan_found && !ptr_q[2];
    assign addr_d   = base_q + ADDR_W'(scan_lane);
    assign ptr_d    = {1'b0, lane_q} + 3'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            rd_q       <= 1'b0;
            reg_wr_q   <= 1'b0;
            lanes_q    <= '0;
            base_q     <= '0;
            mreg_q     <= '0;
            ptr_q      <= '0;
            lane_q     <= '0;
            tmo_q      <= '0;
            mem_addr_q <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            rf_idx_q   <= '0;
            rf_lane_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rf_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (mem_read_i == mem_write_i) begin
                            err_q <= 1'b1;
                        end else begin
                            rd_q     <= mem_read_i;
                            reg_wr_q <= reg_write_i;
                            lanes_q  <= lane_en_i;
                            base_q   <= base_addr_i;
                            mreg_q   <= mreg_idx_i;
                            ptr_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (scan_hit) begin
                        lane_q     <= scan_lane;
                        tmo_q      <= '0;
                        mem_addr_q <= addr_d;
                        rf_idx_q   <= mreg_q;
                        rf_lane_q  <= scan_lane;
                        if (rd_q) begin
                            mem_re_q <= 1'b1;
                            state_q  <= ST_RD;
                        end else begin
                            mem_we_q <= 1'b1;
                            state_q  <= ST_WR;
                        end
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_RD, ST_WR: begin
                    if (mem_ack_i) begin
                        mem_re_q   <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                        if (state_q == ST_RD) begin
                            rf_we_q    <= reg_wr_q;
                            rf_wdata_q <= mem_rdata_i;
                            state_q    <= ST_WB;
                        end else begin
                            rf_idx_q  <= '0;
                            rf_lane_q <= '0;
                            ptr_q     <= ptr_d;
                            state_q   <= ST_SCAN;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Abort the whole command; lanes already written stay written.
                        mem_re_q   <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                        rf_idx_q   <= '0;
                        rf_lane_q  <= '0;
                        err_q      <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_WB: begin
                    rf_idx_q   <= '0;
                    rf_lane_q  <= '0;
                    rf_wdata_q <= '0;
                    ptr_q      <= ptr_d;
                    state_q    <= ST_SCAN;
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_re_o    = mem_re_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_we_q ? rf_rdata_i : '0;
    assign rf_idx_o    = rf_idx_q;
    assign rf_lane_o   = rf_lane_q;
    assign rf_we_o     = rf_we_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_matrix_xfer_engine.sv
// Self-checking bench for matrix_xfer_engine with a memory responder and register-file model.
module tb_matrix_xfer_engine;
    import matrix_xfer_engine_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int MREG_W = 3;

    logic              clk = 1'b0;
    logic              reset, start, mem_read, mem_write, reg_write;
    logic [3:0]        lane_en;
    logic [ADDR_W-1:0] base_addr, mem_addr;
    logic [MREG_W-1:0] mreg_idx, rf_idx;
    logic              mem_re, mem_we, mem_ack, rf_we, busy, done, err;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, rf_wdata, rf_rdata;
    logic [1:0]        rf_lane;
    logic [2:0]        state;

    logic [DATA_W-1:0] rf_mem [8][4];
    assign rf_rdata = rf_mem[rf_idx][rf_lane];

    matrix_xfer_engine dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .reg_write_i(reg_write),
        .lane_en_i(lane_en), .base_addr_i(base_addr), .mreg_idx_i(mreg_idx),
        .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .rf_idx_o(rf_idx), .rf_lane_o(rf_lane), .rf_we_o(rf_we),
        .rf_wdata_o(rf_wdata), .rf_rdata_i(rf_rdata),
        .busy_o(busy), .done_o(done), .err_o(err), .state_o(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    // Observed-event bookkeeping filled by the bus model.
    int re_cycles, we_cycles, both_cnt, busy_seen, done_cnt, err_cnt;
    int done_cyc, err_cyc, wait_cnt, ack_delay;
    bit ack_never;
    logic [39:0] obs_rf_q[$];
    logic [39:0] obs_mw_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] exp_mw_q[$];

    function automatic logic [39:0] pack_rf(input logic [2:0] idx, input logic [1:0] lane,
                                            input logic [31:0] data);
        return {3'd0, idx, lane, data};
    endfunction

    // Memory responder + monitor: ack after ack_delay wait cycles, rdata = addr*3.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (mem_re && mem_we) both_cnt++;
            if (mem_re) re_cycles++;
            if (mem_we) we_cycles++;
            if (busy) busy_seen++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (rf_we) obs_rf_q.push_back(pack_rf(rf_idx, rf_lane, rf_wdata));
            if (mem_re || mem_we) begin
                if (!ack_never && wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_re ? (32'(mem_addr) * 32'd3) : '0;
                    if (mem_we) obs_mw_q.push_back({mem_addr, mem_wdata});
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = '0;
                end
                wait_cnt++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wait_cnt  = 0;
            end
        end
    end

    task automatic clear_obs();
        re_cycles = 0; we_cycles = 0; both_cnt = 0; busy_seen = 0;
        done_cyc = -1; err_cyc = -1;
        obs_rf_q.delete(); obs_mw_q.delete(); exp_q.delete(); exp_mw_q.delete();
    endtask

    task automatic issue(input logic rd, input logic wr, input logic rw, input logic [3:0] le,
                         input logic [7:0] base, input logic [2:0] idx, output int c0);
        @(negedge clk);
        mem_read = rd; mem_write = wr; reg_write = rw;
        lane_en = le; base_addr = base; mreg_idx = idx;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start     = 1'b0;
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        reg_write = 1'($urandom_range(0, 1));
        lane_en   = 4'($urandom_range(0, 15));
        base_addr = 8'($urandom_range(0, 255));
        mreg_idx  = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_end(input int budget, output bit ok);
        int d0 = done_cnt;
        int e0 = err_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_re, mem_we, rf_we, busy, done, err} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000000", {mem_re, mem_we, rf_we, busy, done, err});
        end
        checks++;
        if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        checks++;
        if ({mem_addr, rf_idx, rf_lane} !== 13'd0) begin
            errors++; $display("FAIL reset_addr: got %0h expected 0", {mem_addr, rf_idx, rf_lane});
        end
        checks++;
        if ({rf_wdata, mem_wdata} !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %0h expected 0", {rf_wdata, mem_wdata});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_all();
        int c0; bit ok; logic [39:0] e, g;
        clear_obs(); ack_delay = 0;
        for (int l = 0; l < 4; l++) exp_q.push_back(pack_rf(3'd3, 2'(l), 32'h30 + 32'(3 * l)));
        issue(1'b1, 1'b0, 1'b1, 4'b1111, 8'h10, 3'd3, c0);
        wait_end(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_all_timeout: got no done expected done"); end
        checks++;
        if (done_cyc - c0 != 14) begin errors++; $display("FAIL load_all_latency: got %0d expected 14", done_cyc - c0); end
        checks++;
        if (obs_rf_q.size() != 4) begin errors++; $display("FAIL load_all_count: got %0d expected 4", obs_rf_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (obs_rf_q.size() > 0) ? obs_rf_q.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL load_all_rf: got %0h expected %0h", g, e); end
        end
        checks++;
        if (re_cycles != 4 || we_cycles != 0) begin
            errors++; $display("FAIL load_all_traffic: got re=%0d we=%0d expected re=4 we=0", re_cycles, we_cycles);
        end
    endtask

    task automatic test_store_sparse();
        int c0; bit ok; logic [39:0] e, g;
        clear_obs(); ack_delay = 0;
        for (int l = 0; l < 4; l++) rf_mem[5][l] = 32'hA0 + 32'(l);
        exp_mw_q.push_back({8'hFF, 32'hA1});
        exp_mw_q.push_back({8'h01, 32'hA3});
        issue(1'b0, 1'b1, 1'b0, 4'b1010, 8'hFE, 3'd5, c0);
        wait_end(40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL store_timeout: got no done expected done"); end
        checks++;
        if (done_cyc - c0 != 6) begin errors++; $display("FAIL store_latency: got %0d expected 6", done_cyc - c0); end
        checks++;
        if (obs_mw_q.size() != 2) begin errors++; $display("FAIL store_count: got %0d expected 2", obs_mw_q.size()); end
        while (exp_mw_q.size() > 0) begin
            e = exp_mw_q.pop_front();
            g = (obs_mw_q.size() > 0) ? obs_mw_q.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL store_write: got %0h expected %0h", g, e); end
        end
        checks++;
        if (re_cycles != 0 || obs_rf_q.size() != 0 || both_cnt != 0) begin
            errors++; $display("FAIL store_side: got re=%0d rfw=%0d both=%0d expected 0 0 0", re_cycles, obs_rf_q.size(), both_cnt);
        end
    endtask

    task automatic test_illegal();
        int c0; int d0;
        for (int k = 0; k < 2; k++) begin
            clear_obs(); d0 = done_cnt;
            issue(k == 0, k == 0, 1'b1, 4'b1111, 8'h00, 3'd1, c0);
            repeat (4) @(negedge clk);
            checks++;
            if (err_cyc - c0 != 1) begin errors++; $display("FAIL illegal_err_%0d: got %0d expected 1", k, err_cyc - c0); end
            checks++;
            if (busy_seen != 0 || re_cycles != 0 || we_cycles != 0 || done_cnt != d0) begin
                errors++; $display("FAIL illegal_quiet_%0d: got busy=%0d re=%0d we=%0d done=%0d expected 0 0 0 0",
                                   k, busy_seen, re_cycles, we_cycles, done_cnt - d0);
            end
        end
    endtask

    task automatic test_slow_and_timeout();
        int c0; bit ok; int e0; logic [39:0] g;
        for (int k = 0; k < 2; k++) begin
            clear_obs(); ack_delay = (k == 0) ? 5 : 14; e0 = err_cnt;
            issue(1'b1, 1'b0, 1'b1, 4'b0001, 8'h08, 3'd2, c0);
            wait_end(60, ok);
            checks++;
            if (!ok || err_cnt != e0 || re_cycles != ack_delay + 1) begin
                errors++; $display("FAIL slow_%0d: got ok=%0d err=%0d re=%0d expected 1 0 %0d",
                                   k, ok, err_cnt - e0, re_cycles, ack_delay + 1);
            end
            checks++;
            if (done_cyc - c0 != ack_delay + 5) begin
                errors++; $display("FAIL slow_latency_%0d: got %0d expected %0d", k, done_cyc - c0, ack_delay + 5);
            end
            g = (obs_rf_q.size() > 0) ? obs_rf_q.pop_front() : 'x;
            checks++;
            if (g !== pack_rf(3'd2, 2'd0, 32'h18)) begin
                errors++; $display("FAIL slow_rf_%0d: got %0h expected %0h", k, g, pack_rf(3'd2, 2'd0, 32'h18));
            end
        end
        clear_obs(); ack_never = 1'b1; e0 = err_cnt;
        issue(1'b1, 1'b0, 1'b1, 4'b0001, 8'h08, 3'd2, c0);
        wait_end(60, ok);
        ack_never = 1'b0;
        checks++;
        if (!ok || err_cnt != e0 + 1) begin errors++; $display("FAIL timeout_err: got ok=%0d err=%0d expected 1 1", ok, err_cnt - e0); end
        checks++;
        if (err_cyc - c0 != 17 || done_cyc != err_cyc) begin
            errors++; $display("FAIL timeout_timing: got err=%0d done=%0d expected 17 17", err_cyc - c0, done_cyc - c0);
        end
        checks++;
        if (re_cycles != 15 || obs_rf_q.size() != 0) begin
            errors++; $display("FAIL timeout_hold: got re=%0d rfw=%0d expected 15 0", re_cycles, obs_rf_q.size());
        end
        checks++;
        if (busy !== 1'b0 || state !== S_IDLE) begin
            errors++; $display("FAIL timeout_idle: got busy=%b state=%0d expected 0 0", busy, state);
        end
    endtask

    task automatic test_reset_mid();
        int c0; bit ok; bit hit; logic [39:0] e, g;
        clear_obs(); ack_delay = 0;
        exp_q.push_back(pack_rf(3'd4, 2'd0, 32'hC0));
        exp_q.push_back(pack_rf(3'd4, 2'd1, 32'hC3));
        issue(1'b1, 1'b0, 1'b1, 4'b1111, 8'h40, 3'd4, c0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (rf_we && rf_lane == 2'd1) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_wb: got no lane1 writeback expected writeback"); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_re, mem_we, rf_we, busy, done, err, state} !== 9'd0) begin
            errors++; $display("FAIL reset_mid_clear: got %b expected 0", {mem_re, mem_we, rf_we, busy, done, err, state});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_rf_q.size() != 2) begin errors++; $display("FAIL reset_mid_count: got %0d expected 2", obs_rf_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (obs_rf_q.size() > 0) ? obs_rf_q.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL reset_mid_rf: got %0h expected %0h", g, e); end
        end
        clear_obs();
        issue(1'b1, 1'b0, 1'b1, 4'b0100, 8'h50, 3'd7, c0);
        wait_end(40, ok);
        g = (obs_rf_q.size() > 0) ? obs_rf_q.pop_front() : 'x;
        checks++;
        if (!ok || done_cyc - c0 != 5 || g !== pack_rf(3'd7, 2'd2, 32'hF6)) begin
            errors++; $display("FAIL reset_restart: got ok=%0d lat=%0d rf=%0h expected 1 5 %0h",
                               ok, done_cyc - c0, g, pack_rf(3'd7, 2'd2, 32'hF6));
        end
    endtask

    task automatic test_empty_and_busy_start();
        int c0; bit ok; logic [39:0] e, g;
        clear_obs();
        issue(1'b1, 1'b0, 1'b1, 4'b0000, 8'h30, 3'd1, c0);
        wait_end(20, ok);
        checks++;
        if (!ok || done_cyc - c0 != 2 || re_cycles + we_cycles != 0) begin
            errors++; $display("FAIL empty_mask: got ok=%0d lat=%0d traffic=%0d expected 1 2 0", ok, done_cyc - c0, re_cycles + we_cycles);
        end
        clear_obs(); ack_delay = 0;
        for (int l = 0; l < 4; l++) exp_q.push_back(pack_rf(3'd6, 2'(l), 32'h60 + 32'(3 * l)));
        issue(1'b1, 1'b0, 1'b1, 4'b1111, 8'h20, 3'd6, c0);
        repeat (2) @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; lane_en = 4'b0001; base_addr = 8'h99; mreg_idx = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(60, ok);
        checks++;
        if (!ok || done_cyc - c0 != 14 || we_cycles != 0) begin
            errors++; $display("FAIL busy_start: got ok=%0d lat=%0d we=%0d expected 1 14 0", ok, done_cyc - c0, we_cycles);
        end
        checks++;
        if (obs_rf_q.size() != 4) begin errors++; $display("FAIL busy_start_count: got %0d expected 4", obs_rf_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (obs_rf_q.size() > 0) ? obs_rf_q.pop_front() : 'x;
            checks++;
            if (g !== e) begin errors++; $display("FAIL busy_start_rf: got %0h expected %0h", g, e); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        lane_en = '0; base_addr = '0; mreg_idx = '0;
        ack_delay = 0; ack_never = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int l = 0; l < 4; l++) rf_mem[i][l] = '0;
        test_reset();
        test_load_all();
        test_store_sparse();
        test_illegal();
        test_slow_and_timeout();
        test_reset_mid();
        test_empty_and_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
